// File: rtl/aire_pkg.sv
// Shared codes for the air-conditioner control FSM and its actuator stage.
package aire_pkg;

    localparam logic [1:0] SPD_NONE = 2'b00;
    localparam logic [1:0] SPD_LOW  = 2'b01;
    localparam logic [1:0] SPD_MID  = 2'b10;
    localparam logic [1:0] SPD_HIGH = 2'b11;

    localparam logic [2:0] RNG_1 = 3'b001;
    localparam logic [2:0] RNG_2 = 3'b010;
    localparam logic [2:0] RNG_3 = 3'b011;
    localparam logic [2:0] RNG_4 = 3'b100;

    localparam logic [1:0] EST_OFF = 2'b00;

    typedef enum logic [1:0] {
        C_OFF,
        C_START,
        C_RUN,
        C_LOCKOUT
    } comp_state_e;

    // Ranges 1..3 call for cooling; range 4 and invalid codes do not.
    function automatic logic rng_demand(input logic [2:0] rng);
        return (rng == RNG_1) || (rng == RNG_2) || (rng == RNG_3);
    endfunction

endpackage

// File: rtl/aire_pwm.sv
// Free-running fan PWM; a new duty is only taken at the end of a period.
module aire_pwm #(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                pwm_o
);

    localparam logic [PWM_BITS-1:0] CntMax = '1;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        duty_d = (cnt_q == CntMax) ? duty_i : duty_q;
        pwm_d  = (cnt_q < duty_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign duty_o = duty_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/aire_actuador.sv
// Plant driver: soft-ramped fan PWM plus compressor enable with anti-short-cycle timing.
module aire_actuador
    import aire_pkg::*;
#(
    parameter int unsigned PWM_BITS  = 4,
    parameter int unsigned RAMP_DIV  = 8,
    parameter int unsigned DUTY_LOW  = 5,
    parameter int unsigned DUTY_MID  = 10,
    parameter int unsigned DUTY_HIGH = 15,
    parameter int unsigned START_DLY = 16,
    parameter int unsigned MIN_RUN   = 32,
    parameter int unsigned MIN_OFF   = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          estado,
    input  logic [1:0]          velocidad,
    input  logic [2:0]          temperatura,
    output logic                fan_pwm,
    output logic [PWM_BITS-1:0] fan_duty,
    output logic                comp_on,
    output logic                comp_lock
);

    localparam int unsigned RampW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned MaxA   = (START_DLY > MIN_RUN) ? START_DLY : MIN_RUN;
    localparam int unsigned MaxCnt = (MaxA > MIN_OFF) ? MaxA : MIN_OFF;
    localparam int unsigned TimerW = $clog2(MaxCnt + 1);

    localparam logic [PWM_BITS-1:0] DutyLow  = PWM_BITS'(DUTY_LOW);
    localparam logic [PWM_BITS-1:0] DutyMid  = PWM_BITS'(DUTY_MID);
    localparam logic [PWM_BITS-1:0] DutyHigh = PWM_BITS'(DUTY_HIGH);
    localparam logic [RampW-1:0]    RampLast = RampW'(RAMP_DIV - 1);
    localparam logic [TimerW-1:0]   StartLast = TimerW'(START_DLY - 1);
    localparam logic [TimerW-1:0]   RunLast   = TimerW'(MIN_RUN - 1);
    localparam logic [TimerW-1:0]   OffLast   = TimerW'(MIN_OFF - 1);
    localparam logic [TimerW-1:0]   TimerMax  = '1;

    logic [PWM_BITS-1:0] target;
    logic [RampW-1:0]    ramp_cnt_q, ramp_cnt_d;
    logic [PWM_BITS-1:0] duty_ramp_q, duty_ramp_d;
    logic                ramp_wrap;
    logic                demand;

    comp_state_e         state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d, timer_inc;
    logic                comp_on_q, comp_lock_q;

    always_comb begin
        target = '0;
        if (estado != EST_OFF) begin
            unique case (velocidad)
                SPD_LOW:  target = DutyLow;
                SPD_MID:  target = DutyMid;
                SPD_HIGH: target = DutyHigh;
                default:  target = '0;
            endcase
        end
    end

    assign ramp_wrap = (ramp_cnt_q == RampLast);

    always_comb begin
        ramp_cnt_d  = ramp_wrap ? '0 : ramp_cnt_q + 1'b1;
        duty_ramp_d = duty_ramp_q;
        if (ramp_wrap) begin
            if (duty_ramp_q < target) begin
                duty_ramp_d = duty_ramp_q + 1'b1;
            end else if (duty_ramp_q > target) begin
                duty_ramp_d = duty_ramp_q - 1'b1;
            end
        end
    end

    aire_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clock  (clock),
        .reset  (reset),
        .duty_i (duty_ramp_q),
        .duty_o (fan_duty),
        .pwm_o  (fan_pwm)
    );

    assign demand = (estado != EST_OFF) && rng_demand(temperatura);

    always_comb begin
        state_d   = state_q;
        timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
        timer_d   = timer_inc;
        unique case (state_q)
            C_OFF: begin
                if (demand) state_d = C_START;
            end
            C_START: begin
                if (!demand) begin
                    state_d = C_OFF;
                end else if (fan_duty < DutyLow) begin
                    // Start delay only counts while the fan is actually moving air.
                    timer_d = '0;
                end else if (timer_q >= StartLast) begin
                    state_d = C_RUN;
                end
            end
            C_RUN: begin
                // Power-off wins over the minimum run time.
                if ((estado == EST_OFF) || ((timer_q >= RunLast) && !demand)) begin
                    state_d = C_LOCKOUT;
                end
            end
            C_LOCKOUT: begin
                if (timer_q >= OffLast) state_d = C_OFF;
            end
            default: state_d = C_OFF;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ramp_cnt_q  <= '0;
            duty_ramp_q <= '0;
            state_q     <= C_OFF;
            timer_q     <= '0;
            comp_on_q   <= 1'b0;
            comp_lock_q <= 1'b0;
        end else begin
            ramp_cnt_q  <= ramp_cnt_d;
            duty_ramp_q <= duty_ramp_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            comp_on_q   <= (state_d == C_RUN);
            comp_lock_q <= (state_d == C_LOCKOUT);
        end
    end

    assign comp_on   = comp_on_q;
    assign comp_lock = comp_lock_q;

endmodule
